// File: rtl/ctrl_def.sv
// rtl/ctrl_def.sv - shared encodings and helpers for pipeline hazard control
package ctrl_def;

    localparam int REG_W     = 5;
    localparam int MDU_CNT_W = 6;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // A source only depends on a producer when it is actually read and is not r0.
    function automatic logic src_hit(input logic used, input reg_idx_t src, input reg_idx_t dst);
        return used && (dst != '0) && (src == dst);
    endfunction

    function automatic fwd_sel_e fwd_pick(input logic mem_wr, input reg_idx_t mem_rd,
                                          input logic wb_wr, input reg_idx_t wb_rd,
                                          input reg_idx_t src);
        if (src_hit(mem_wr, src, mem_rd)) begin
            return FWD_EXMEM;
        end
        if (src_hit(wb_wr, src, wb_rd)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multiply/divide occupancy sequencer (IDLE/BUSY/DONE)
module mdu_sequencer
    import ctrl_def::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_CYCLES - 1);

    mdu_state_e            state_q, state_d;
    logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loading MDU_CYCLES-1 and leaving on zero gives exactly MDU_CYCLES cycles in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use/MDU stall and branch flush control
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_ctrl
    import ctrl_def::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic           id_use_hilo,
    input  logic           id_mdu_start,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic           ex_regwrite,
    input  logic           ex_memread,
    input  logic           ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic           mem_regwrite,
    input  logic           wb_regwrite,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b,
    output logic           pc_stall,
    output logic           ifid_stall,
    output logic           ifid_flush,
    output logic           idex_flush,
    output logic           mdu_busy
);

    logic     load_use;
    logic     data_hz;
    logic     mdu_hz;
    logic     stall;
    logic     mdu_start;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;

    assign load_use = ex_memread &&
                      (src_hit(id_use_rs, id_rs, ex_rd) || src_hit(id_use_rt, id_rt, ex_rd));

`ifdef HAZARD_FWD_EN
    logic unused_nofwd;
    assign unused_nofwd = ex_regwrite;
    assign fwd_a_sel    = fwd_pick(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs);
    assign fwd_b_sel    = fwd_pick(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rt);
    assign data_hz      = load_use;
`else
    // Without bypass paths, any in-flight EX or MEM producer must drain before ID reads.
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
    assign fwd_a_sel  = FWD_RF;
    assign fwd_b_sel  = FWD_RF;
    assign data_hz    = load_use ||
                        (ex_regwrite  && (src_hit(id_use_rs, id_rs, ex_rd)  || src_hit(id_use_rt, id_rt, ex_rd))) ||
                        (mem_regwrite && (src_hit(id_use_rs, id_rs, mem_rd) || src_hit(id_use_rt, id_rt, mem_rd)));
`endif

    assign mdu_hz    = mdu_busy && (id_use_hilo || id_mdu_start);
    assign stall     = (data_hz || mdu_hz) && !ex_branch_taken;
    assign mdu_start = id_mdu_start && !data_hz && !mdu_hz && !ex_branch_taken;

    mdu_sequencer #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (mdu_start),
        .busy_o  (mdu_busy)
    );

    always_comb begin
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            fwd_a      = fwd_a_sel;
            fwd_b      = fwd_b_sel;
            pc_stall   = stall;
            ifid_stall = stall;
            ifid_flush = ex_branch_taken;
            idex_flush = stall || ex_branch_taken;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (MDU_CYCLES=4)
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, id_use_hilo, id_mdu_start;
    logic       ex_regwrite, ex_memread, ex_branch_taken, mem_regwrite, wb_regwrite;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_busy;

    typedef struct {
        string      tag;
        logic       p_st, i_st, i_fl, x_fl, busy;
        logic [1:0] fa, fb;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl #(.MDU_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_use_hilo     (id_use_hilo),
        .id_mdu_start    (id_mdu_start),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_regwrite    (mem_regwrite),
        .wb_regwrite     (wb_regwrite),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .mdu_busy        (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_use_rs = 0; id_use_rt = 0; id_use_hilo = 0; id_mdu_start = 0;
        ex_regwrite = 0; ex_memread = 0; ex_branch_taken = 0; mem_regwrite = 0; wb_regwrite = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic chk(input string tag, input string fld, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s.%s got=%0b exp=%0b", tag, fld, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic p_st, input logic i_st, input logic i_fl,
                              input logic x_fl, input logic busy, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag = tag; e.p_st = p_st; e.i_st = i_st; e.i_fl = i_fl; e.x_fl = x_fl;
        e.busy = busy; e.fa = fa; e.fb = fb;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk(e.tag, "pc_stall",   {1'b0, pc_stall},   {1'b0, e.p_st});
        chk(e.tag, "ifid_stall", {1'b0, ifid_stall}, {1'b0, e.i_st});
        chk(e.tag, "ifid_flush", {1'b0, ifid_flush}, {1'b0, e.i_fl});
        chk(e.tag, "idex_flush", {1'b0, idex_flush}, {1'b0, e.x_fl});
        chk(e.tag, "mdu_busy",   {1'b0, mdu_busy},   {1'b0, e.busy});
        chk(e.tag, "fwd_a",      fwd_a,              e.fa);
        chk(e.tag, "fwd_b",      fwd_b,              e.fb);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        ex_branch_taken = 1; ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        ex_rs = 5; ex_rt = 5; mem_rd = 5; mem_regwrite = 1;
        expect_out("reset", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); rst = 1'b0;
        expect_out("idle", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_rs = 5; ex_rt = 9; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
        expect_out("fwd_mem", 0, 0, 0, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00);

        next_cycle(); ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; wb_regwrite = 1;
        expect_out("fwd_wb", 0, 0, 0, 0, 0, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);

        next_cycle(); mem_regwrite = 1; wb_regwrite = 1;
        expect_out("fwd_r0", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        expect_out("lu_rs", 1, 1, 0, 1, 0, 2'b00, 2'b00);

        next_cycle(); id_rs = 8; id_use_rs = 1;
        expect_out("lu_bubble", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_memread = 1; ex_rd = 12; id_rt = 12; id_use_rt = 1;
        expect_out("lu_rt", 1, 1, 0, 1, 0, 2'b00, 2'b00);

        next_cycle(); ex_memread = 1; ex_regwrite = 1; id_use_rs = 1;
        expect_out("lu_r0", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_memread = 1; ex_rd = 8; id_rs = 8;
        expect_out("lu_unused", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); mem_rd = 3; mem_regwrite = 1; id_rs = 3; id_use_rs = 1; ex_rs = 3;
        expect_out("nofwd_mem", !FWD, !FWD, 0, !FWD, 0, FWD ? 2'b01 : 2'b00, 2'b00);

        next_cycle(); ex_regwrite = 1; ex_rd = 4; id_rt = 4; id_use_rt = 1;
        expect_out("nofwd_ex", !FWD, !FWD, 0, !FWD, 0, 2'b00, 2'b00);

        next_cycle(); id_mdu_start = 1;
        expect_out("mdu_start", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        next_cycle();
        expect_out("mdu_b1", 0, 0, 0, 0, 1, 2'b00, 2'b00);
        next_cycle(); id_use_hilo = 1;
        expect_out("mdu_b2_hilo", 1, 1, 0, 1, 1, 2'b00, 2'b00);
        next_cycle(); id_mdu_start = 1;
        expect_out("mdu_b3_start", 1, 1, 0, 1, 1, 2'b00, 2'b00);
        next_cycle(); ex_branch_taken = 1; id_use_hilo = 1;
        expect_out("mdu_b4_branch", 0, 0, 1, 1, 1, 2'b00, 2'b00);
        next_cycle(); id_use_hilo = 1;
        expect_out("mdu_done", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        next_cycle();
        expect_out("mdu_idle", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; id_mdu_start = 1;
        expect_out("prio", 0, 0, 1, 1, 0, 2'b00, 2'b00);
        next_cycle();
        expect_out("prio_nostart", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; id_mdu_start = 1;
        expect_out("lu_start", 1, 1, 0, 1, 0, 2'b00, 2'b00);
        next_cycle();
        expect_out("lu_nostart", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        next_cycle(); id_mdu_start = 1;
        expect_out("rst_start", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        next_cycle();
        expect_out("rst_b1", 0, 0, 0, 0, 1, 2'b00, 2'b00);
        next_cycle();
        expect_out("rst_b2", 0, 0, 0, 0, 1, 2'b00, 2'b00);
        next_cycle(); id_use_hilo = 1; rst = 1'b1;
        expect_out("rst_mid", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        next_cycle(); rst = 1'b0; id_mdu_start = 1;
        expect_out("rst_restart", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            expect_out($sformatf("rst_busy%0d", i), 0, 0, 0, 0, 1, 2'b00, 2'b00);
        end
        next_cycle();
        expect_out("rst_end", 0, 0, 0, 0, 0, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_CYCLES, default 32, giving the multiply/divide occupancy in cycles (legal 2..63).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports id_rs, id_rt, input, 5 each, ID-stage source registers.
REQ-006 The block SHALL have ports id_use_rs, id_use_rt, input, 1 each, ID instruction reads that source.
REQ-007 The block SHALL have port id_use_hilo, input, 1, ID instruction reads HI/LO (mfhi/mflo).
REQ-008 The block SHALL have port id_mdu_start, input, 1, ID instruction is mult/div.
REQ-009 The block SHALL have ports ex_rs, ex_rt, ex_rd, input, 5 each, EX-stage register fields.
REQ-010 The block SHALL have ports ex_regwrite, ex_memread, input, 1 each, EX writes a register / EX is a load.
REQ-011 The block SHALL have port ex_branch_taken, input, 1, branch/jump resolved taken in EX.
REQ-012 The block SHALL have ports mem_rd, wb_rd, input, 5 each, and mem_regwrite, wb_regwrite, input, 1 each.
REQ-013 The block SHALL have ports fwd_a, fwd_b, output, 2 each, ALU operand A/B select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-014 The block SHALL have ports pc_stall, ifid_stall, ifid_flush, idex_flush, output, 1 each, pipeline control.
REQ-015 The block SHALL have port mdu_busy, output, 1, multiply/divide unit occupied.

Function
REQ-016 Register 0 SHALL never cause a hazard or a forward.
REQ-017 fwd_a SHALL be 01 when mem_regwrite and mem_rd == ex_rs; otherwise 10 when wb_regwrite and wb_rd == ex_rs; otherwise 00. fwd_b SHALL follow the same rule using ex_rt. MEM SHALL take priority over WB.
REQ-018 A load-use hazard SHALL be asserted when ex_memread, ex_rd != 0, and ex_rd matches a used ID source. It SHALL assert pc_stall, ifid_stall and idex_flush combinationally in the same cycle, giving exactly one bubble.
REQ-019 The MDU FSM SHALL have states IDLE, BUSY and DONE.
REQ-020 In IDLE, id_mdu_start with no stall and no flush SHALL enter BUSY and load a 6-bit counter with MDU_CYCLES-1.
REQ-021 In BUSY, the counter SHALL decrement each cycle; when the counter reaches 0, the FSM SHALL go to DONE. DONE SHALL return to IDLE after one cycle.
REQ-022 mdu_busy SHALL be 1 in BUSY and 0 in IDLE and DONE.
REQ-023 While BUSY, id_use_hilo or id_mdu_start SHALL assert pc_stall and ifid_stall and idex_flush.
REQ-024 ex_branch_taken SHALL assert ifid_flush and idex_flush, force pc_stall and ifid_stall to 0, and suppress the load-use and MDU stalls. Flush SHALL win over any simultaneous stall.
REQ-025 id_mdu_start coinciding with a flush or a load-use stall SHALL NOT start the MDU.
REQ-026 A branch flush SHALL NOT abort an MDU operation already in BUSY.

Reset
REQ-027 rst SHALL asynchronously force FSM = IDLE and counter = 0.
REQ-028 While rst is asserted, all stall and flush outputs, mdu_busy, fwd_a and fwd_b SHALL be 0.
REQ-029 Reset mid-BUSY SHALL abandon the operation; the first cycle after reset SHALL accept a new start.

Configuration
REQ-030 With HAZARD_FWD_EN defined, the block SHALL forward per REQ-017.
REQ-031 Without HAZARD_FWD_EN, fwd_a and fwd_b SHALL be held at 00. Any used ID source matching ex_rd (with ex_regwrite) or mem_rd (with mem_regwrite), rd != 0, SHALL stall as in REQ-018.

Structure
REQ-032 The forward-select encodings, MDU state encodings and the 5-bit register index width SHALL be defined in the shared control package (ctrl_def).
REQ-033 The MDU FSM and counter SHALL be a sub-module named mdu_sequencer; the remaining logic SHALL be combinational in hazard_ctrl.

Verification
REQ-034 Forwarding: ex_rs=5, mem_rd=5 with mem_regwrite, wb_rd=5 with wb_regwrite -> fwd_a=01; drop mem_regwrite -> fwd_a=10; ex_rs=0 -> fwd_a=00.
REQ-035 Load-use: ex_memread, ex_rd=8, id_rs=8, id_use_rs -> pc_stall=ifid_stall=idex_flush=1 for exactly one cycle.
REQ-036 MDU: MDU_CYCLES=4, start pulse -> mdu_busy high for exactly 4 cycles; id_use_hilo during busy -> stall; the cycle after busy drops -> no stall.
REQ-037 Priority: ex_branch_taken together with a load-use hazard and id_mdu_start -> ifid_flush=idex_flush=1, pc_stall=0, mdu_busy remains 0.
REQ-038 Reset: assert rst two cycles into BUSY -> mdu_busy=0 immediately; after rst deasserts, a new start -> full MDU_CYCLES busy period.
REQ-039 Without HAZARD_FWD_EN: mem_rd=3 with mem_regwrite, id_rs=3, id_use_rs -> stall asserted, fwd_a=00.
